condicionador_entradas: RTL and testbench

Input-side conditioner for the board's push-buttons and slide switches. It synchronises, debounces and edge-detects the raw pins before the game logic sees them, so that `seletor_mapa` and `gerenciador_de_ataque` receive clean levels and exactly one single-cycle pulse per physical press. It sits between the top-level pins and all game modules, on the input side of the board, opposite to the LED-matrix/display drivers.

---
 rtl/condicionador_entradas.sv | 155 +++++++++++++++
 tb/tb_condicionador_entradas.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_entradas.sv
// Input conditioner: 2-flop synchronisers, debounce FSMs for the active-low buttons
// and stability filters for the slide switches, with single-cycle change pulses.
module condicionador_entradas #(
  parameter int DEBOUNCE_MAX = 50000,
  parameter int CNT_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] btn_n,
  input  logic [7:0] ch,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic [7:0] ch_stable,
  output logic       ch_changed
);

  typedef enum logic [1:0] {
    SOLTO          = 2'd0,
    CONFIRMA_PRESS = 2'd1,
    PRESSIONADO    = 2'd2,
    CONFIRMA_SOLTA = 2'd3
  } btn_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

  // Buttons are inverted ahead of the synchroniser so p is 1 while pressed.
  logic [3:0] p_meta;
  logic [3:0] p;
  logic [7:0] s_meta;
  logic [7:0] s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_meta <= '0;
      p      <= '0;
      s_meta <= '0;
      s      <= '0;
    end else begin
      p_meta <= ~btn_n;
      p      <= p_meta;
      s_meta <= ch;
      s      <= s_meta;
    end
  end

  // Per-button FSM state is kept in one packed array so it can be probed directly.
  btn_state_t [3:0]            btn_state;
  btn_state_t [3:0]            btn_state_next;
  logic       [3:0][CNT_W-1:0] btn_cnt;
  logic       [3:0][CNT_W-1:0] btn_cnt_next;
  logic       [3:0]            press_hit;
  logic       [3:0]            level_next;

  always_comb begin
    btn_state_next = btn_state;
    btn_cnt_next   = btn_cnt;
    press_hit      = '0;
    level_next     = '0;
    for (int i = 0; i < 4; i++) begin
      case (btn_state[i])
        SOLTO: begin
          if (p[i]) begin
            btn_state_next[i] = CONFIRMA_PRESS;
            btn_cnt_next[i]   = '0;
          end
        end
        CONFIRMA_PRESS: begin
          if (!p[i]) begin
            btn_state_next[i] = SOLTO;
          end else if (btn_cnt[i] == CNT_LAST) begin
            btn_state_next[i] = PRESSIONADO;
            press_hit[i]      = 1'b1;
          end else begin
            btn_cnt_next[i] = btn_cnt[i] + 1'b1;
          end
        end
        PRESSIONADO: begin
          if (!p[i]) begin
            btn_state_next[i] = CONFIRMA_SOLTA;
            btn_cnt_next[i]   = '0;
          end
        end
        CONFIRMA_SOLTA: begin
          if (p[i]) begin
            btn_state_next[i] = PRESSIONADO;
          end else if (btn_cnt[i] == CNT_LAST) begin
            btn_state_next[i] = SOLTO;
          end else begin
            btn_cnt_next[i] = btn_cnt[i] + 1'b1;
          end
        end
        default: begin
          btn_state_next[i] = SOLTO;
          btn_cnt_next[i]   = '0;
        end
      endcase
      level_next[i] = (btn_state_next[i] == PRESSIONADO) ||
                      (btn_state_next[i] == CONFIRMA_SOLTA);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_state <= {4{SOLTO}};
      btn_cnt   <= '0;
      btn_level <= '0;
      btn_pulse <= '0;
    end else begin
      btn_state <= btn_state_next;
      btn_cnt   <= btn_cnt_next;
      btn_level <= level_next;
      btn_pulse <= press_hit;
    end
  end

  // Switch filters: count while the synchronised value disagrees with the accepted one.
  logic [7:0][CNT_W-1:0] sw_cnt;
  logic [7:0][CNT_W-1:0] sw_cnt_next;
  logic [7:0]            sw_upd;
  logic [7:0]            sw_upd_q;
  logic [7:0]            stable_next;

  always_comb begin
    sw_cnt_next = sw_cnt;
    sw_upd      = '0;
    stable_next = ch_stable;
    for (int j = 0; j < 8; j++) begin
      if (s[j] == ch_stable[j]) begin
        sw_cnt_next[j] = '0;
      end else if (sw_cnt[j] == CNT_LAST) begin
        sw_upd[j]      = 1'b1;
        stable_next[j] = s[j];
        sw_cnt_next[j] = '0;
      end else begin
        sw_cnt_next[j] = sw_cnt[j] + 1'b1;
      end
    end
  end

  // ch_changed lands one cycle after ch_stable and merges coincident bit updates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_cnt     <= '0;
      ch_stable  <= '0;
      sw_upd_q   <= '0;
      ch_changed <= 1'b0;
    end else begin
      sw_cnt     <= sw_cnt_next;
      ch_stable  <= stable_next;
      sw_upd_q   <= sw_upd;
      ch_changed <= |sw_upd_q;
    end
  end

endmodule

// File: tb/tb_condicionador_entradas.sv
// Directed bench for condicionador_entradas with DEBOUNCE_MAX=4; each task checks
// its own scenario against hand-computed edge counts.
module tb_condicionador_entradas;

  logic       clock;
  logic       reset;
  logic [3:0] btn_n;
  logic [7:0] ch;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic [7:0] ch_stable;
  logic       ch_changed;

  int total;
  int bad;

  condicionador_entradas #(
    .DEBOUNCE_MAX(4),
    .CNT_W       (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_n     (btn_n),
    .ch        (ch),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .ch_stable (ch_stable),
    .ch_changed(ch_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    btn_n = 4'hF;
    ch    = 8'h00;
    tick();
    tick();
    total++;
    if ({btn_level, btn_pulse, ch_stable, ch_changed} !== 17'h0) begin
      bad++;
      $display("FAIL reset_hold: got level=%b pulse=%b stable=%h changed=%b, want all 0",
               btn_level, btn_pulse, ch_stable, ch_changed);
    end
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++;
      if ({btn_level, btn_pulse, ch_stable, ch_changed} !== 17'h0) begin
        bad++;
        $display("FAIL reset_idle edge %0d: got level=%b pulse=%b stable=%h changed=%b, want all 0",
                 k, btn_level, btn_pulse, ch_stable, ch_changed);
      end
    end
  endtask

  task automatic test_press_release;
    logic [3:0] exp_p;
    logic [3:0] exp_l;
    btn_n = 4'b1011;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_p = (k == 7) ? 4'b0100 : 4'b0000;
      exp_l = (k >= 7) ? 4'b0100 : 4'b0000;
      total++;
      if (btn_pulse !== exp_p || btn_level !== exp_l) begin
        bad++;
        $display("FAIL press edge %0d: got pulse=%b level=%b, want pulse=%b level=%b",
                 k, btn_pulse, btn_level, exp_p, exp_l);
      end
    end
    btn_n = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_l = (k < 7) ? 4'b0100 : 4'b0000;
      total++;
      if (btn_pulse !== 4'b0000 || btn_level !== exp_l) begin
        bad++;
        $display("FAIL release edge %0d: got pulse=%b level=%b, want pulse=0000 level=%b",
                 k, btn_pulse, btn_level, exp_l);
      end
    end
  endtask

  task automatic test_bounce;
    logic [3:0] exp_p;
    logic [3:0] exp_l;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 5; k++) begin
        btn_n = (k < 3) ? 4'b1110 : 4'b1111;
        tick();
        total++;
        if (btn_pulse !== 4'b0000 || btn_level !== 4'b0000) begin
          bad++;
          $display("FAIL bounce rep %0d step %0d: got pulse=%b level=%b, want 0000 0000",
                   r, k, btn_pulse, btn_level);
        end
      end
    end
    btn_n = 4'b1110;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_p = (k == 7) ? 4'b0001 : 4'b0000;
      exp_l = (k >= 7) ? 4'b0001 : 4'b0000;
      total++;
      if (btn_pulse !== exp_p || btn_level !== exp_l) begin
        bad++;
        $display("FAIL bounce_hold edge %0d: got pulse=%b level=%b, want pulse=%b level=%b",
                 k, btn_pulse, btn_level, exp_p, exp_l);
      end
    end
    btn_n = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_l = (k < 7) ? 4'b0001 : 4'b0000;
      total++;
      if (btn_pulse !== 4'b0000 || btn_level !== exp_l) begin
        bad++;
        $display("FAIL bounce_release edge %0d: got pulse=%b level=%b, want pulse=0000 level=%b",
                 k, btn_pulse, btn_level, exp_l);
      end
    end
  endtask

  task automatic test_switch;
    logic [7:0] exp_s;
    logic       exp_c;
    ch = 8'hA5;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_s = (k >= 6) ? 8'hA5 : 8'h00;
      exp_c = (k == 7);
      total++;
      if (ch_stable !== exp_s || ch_changed !== exp_c) begin
        bad++;
        $display("FAIL switch_a5 edge %0d: got stable=%h changed=%b, want stable=%h changed=%b",
                 k, ch_stable, ch_changed, exp_s, exp_c);
      end
    end
    for (int k = 1; k <= 12; k++) begin
      ch = (k <= 2) ? 8'hA4 : 8'hA5;
      tick();
      total++;
      if (ch_stable !== 8'hA5 || ch_changed !== 1'b0) begin
        bad++;
        $display("FAIL switch_glitch edge %0d: got stable=%h changed=%b, want stable=a5 changed=0",
                 k, ch_stable, ch_changed);
      end
    end
    ch = 8'h5A;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_s = (k >= 6) ? 8'h5A : 8'hA5;
      exp_c = (k == 7);
      total++;
      if (ch_stable !== exp_s || ch_changed !== exp_c) begin
        bad++;
        $display("FAIL switch_5a edge %0d: got stable=%h changed=%b, want stable=%h changed=%b",
                 k, ch_stable, ch_changed, exp_s, exp_c);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_p;
    logic [3:0] exp_l;
    btn_n = 4'b0101;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_p = (k == 7) ? 4'b1010 : 4'b0000;
      exp_l = (k >= 7) ? 4'b1010 : 4'b0000;
      total++;
      if (btn_pulse !== exp_p || btn_level !== exp_l) begin
        bad++;
        $display("FAIL dual_press edge %0d: got pulse=%b level=%b, want pulse=%b level=%b",
                 k, btn_pulse, btn_level, exp_p, exp_l);
      end
    end
    btn_n = 4'hF;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_l = (k < 7) ? 4'b1010 : 4'b0000;
      total++;
      if (btn_pulse !== 4'b0000 || btn_level !== exp_l) begin
        bad++;
        $display("FAIL dual_release edge %0d: got pulse=%b level=%b, want pulse=0000 level=%b",
                 k, btn_pulse, btn_level, exp_l);
      end
    end
  endtask

  // Reset while the switches sit at 5a: ch_stable re-acquires them and pulses ch_changed.
  task automatic reset_and_reacquire(input string tag);
    logic [3:0] exp_p;
    logic [3:0] exp_l;
    logic [7:0] exp_s;
    logic       exp_c;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({btn_level, btn_pulse, ch_stable, ch_changed} !== 17'h0) begin
      bad++;
      $display("FAIL %s_async: got level=%b pulse=%b stable=%h changed=%b, want all 0",
               tag, btn_level, btn_pulse, ch_stable, ch_changed);
    end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_p = (k == 7) ? 4'b1000 : 4'b0000;
      exp_l = (k >= 7) ? 4'b1000 : 4'b0000;
      exp_s = (k >= 6) ? 8'h5A : 8'h00;
      exp_c = (k == 7);
      total++;
      if (btn_pulse !== exp_p || btn_level !== exp_l ||
          ch_stable !== exp_s || ch_changed !== exp_c) begin
        bad++;
        $display("FAIL %s_after edge %0d: got pulse=%b level=%b stable=%h changed=%b, want %b %b %h %b",
                 tag, k, btn_pulse, btn_level, ch_stable, ch_changed,
                 exp_p, exp_l, exp_s, exp_c);
      end
    end
  endtask

  task automatic test_reset_mid;
    btn_n = 4'b0111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (btn_pulse !== 4'b0000 || btn_level !== 4'b0000) begin
        bad++;
        $display("FAIL mid_confirm edge %0d: got pulse=%b level=%b, want 0000 0000",
                 k, btn_pulse, btn_level);
      end
    end
    reset_and_reacquire("reset_confirm");
    reset_and_reacquire("reset_held");
    btn_n = 4'hF;
    for (int k = 1; k <= 8; k++) tick();
    total++;
    if (btn_level !== 4'b0000 || btn_pulse !== 4'b0000) begin
      bad++;
      $display("FAIL final_release: got level=%b pulse=%b, want 0000 0000", btn_level, btn_pulse);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    btn_n = 4'hF;
    ch    = 8'h00;
    test_reset();
    test_press_release();
    test_bounce();
    test_switch();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
